// File: rtl/duv_pkg.sv
// Shared definitions for the duv_top Wishbone-classic slave memory.
// Holds the default bus geometry (data width, word-address width, byte-address
// width), the two-state response FSM encoding and the bus field typedefs.
package duv_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 8;
  localparam int BAW_DEF = 26;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  typedef logic [BAW_DEF-1:0]    wb_addr_t;
  typedef logic [DW_DEF-1:0]     wb_data_t;
  typedef logic [DW_DEF/8-1:0]   wb_sel_t;

endpackage

// File: rtl/duv_bytemem.sv
// Single-port word array with per-byte write enables and a registered read
// port. No reset: contents are undefined until written.
// Ports:
//   clk    - rising-edge clock
//   addr   - word index
//   wr_en  - write strobe; lanes selected by be are updated
//   be     - byte-lane enables
//   wdata  - write data
//   rd_en  - read strobe; rdata captures mem[addr] at this edge
//   rdata  - registered read data, holds between reads
module duv_bytemem
  import duv_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr,
  input  logic            wr_en,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   wdata,
  input  logic            rd_en,
  output logic [DW-1:0]   rdata
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/duv_top.sv
// Wishbone-classic slave memory. Accepts one read/write per two cycles,
// answers each with a single-cycle ack (in range) or err (out of range) and
// counts completed writes and reads.
// Ports:
//   sys_clk, rst         - clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i   - request qualifiers (request = cyc & stb)
//   wb_we_i              - 1 = write, 0 = read
//   wb_addr_i            - byte address, bits [1:0] ignored
//   wb_sel_i, wb_dat_i   - write byte lanes and write data
//   wb_dat_o             - read data, valid with wb_ack_o, held otherwise
//   wb_ack_o, wb_err_o   - one-cycle completion / error pulses
//   wr_count, rd_count   - wrapping counts of acked writes / reads
module duv_top
  import duv_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int BAW = BAW_DEF
) (
  input  logic            sys_clk,
  input  logic            rst,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [BAW-1:0]  wb_addr_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [15:0]     wr_count,
  output logic [15:0]     rd_count
);

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          dvld_q, dvld_d;
  logic [15:0]   wr_count_q, wr_count_d;
  logic [15:0]   rd_count_q, rd_count_d;

  logic          req;
  logic          accept;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          unused_addr_lsb;

  assign req      = wb_cyc_i & wb_stb_i;
  assign word_idx = wb_addr_i[AW+1:2];
  assign in_range = (wb_addr_i[BAW-1:AW+2] == '0);
  // Requests are only taken in IDLE, so a request held through RESP is not
  // re-accepted and throughput is one transfer per two cycles.
  assign accept   = (state_q == IDLE) && req;
  assign mem_we   = accept & wb_we_i & in_range;
  assign mem_re   = accept & ~wb_we_i & in_range;

  // Byte lanes select the word inside the bus address only.
  assign unused_addr_lsb = ^wb_addr_i[1:0];

  duv_bytemem #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk  (sys_clk),
    .addr (word_idx),
    .wr_en(mem_we),
    .be   (wb_sel_i),
    .wdata(wb_dat_i),
    .rd_en(mem_re),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dvld_d     = dvld_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RESP;
          if (in_range) begin
            ack_d = 1'b1;
            if (wb_we_i) begin
              wr_count_d = wr_count_q + 16'd1;
            end else begin
              rd_count_d = rd_count_q + 16'd1;
              dvld_d     = 1'b1;
            end
          end else begin
            err_d  = 1'b1;
            dvld_d = 1'b0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dvld_q     <= 1'b0;
      wr_count_q <= 16'd0;
      rd_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dvld_q     <= dvld_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  // The array's read register has no reset and holds across writes; dvld_q
  // forces zero after reset or after an out-of-range access.
  assign wb_dat_o = dvld_q ? mem_rdata : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_duv_top.sv
// Self-checking bench for duv_top: directed scenarios followed by random
// transfers checked against a word-array reference model.
module tb_duv_top;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [25:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dati = '0;
  logic [31:0] dato;
  logic        ack;
  logic        err;
  logic [15:0] wrc;
  logic [15:0] rdc;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [256];
  logic [15:0] mwr = 16'd0;
  logic [15:0] mrd = 16'd0;
  logic [31:0] m_dat = 32'd0;

  always #5 sys_clk = ~sys_clk;

  duv_top dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_addr_i(addr),
    .wb_sel_i (sel),
    .wb_dat_i (dati),
    .wb_dat_o (dato),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wr_count (wrc),
    .rd_count (rdc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transfer: request, sample response, release, return to idle.
  task automatic transact(input logic w, input logic [25:0] a, input logic [3:0] s,
                          input logic [31:0] d, input string tag);
    bit inr;
    int idx;
    we = w; addr = a; sel = s; dati = d; cyc = 1'b1; stb = 1'b1;
    @(posedge sys_clk); #1;
    inr = (a < 26'd1024);
    idx = int'(a) / 4;
    if (inr) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        mwr = mwr + 16'd1;
      end else begin
        m_dat = mdl[idx];
        mrd = mrd + 16'd1;
      end
    end else begin
      m_dat = 32'd0;
    end
    chk({tag, "_ack"}, {31'd0, ack}, {31'd0, inr});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, !inr});
    chk({tag, "_dat"}, dato, m_dat);
    chk({tag, "_wrc"}, {16'd0, wrc}, {16'd0, mwr});
    chk({tag, "_rdc"}, {16'd0, rdc}, {16'd0, mrd});
    cyc = 1'b0; stb = 1'b0;
    @(posedge sys_clk); #1;
    chk({tag, "_end"}, {30'd0, ack, err}, 32'd0);
  endtask

  initial begin
    logic [5:0]  pat;
    int          nack;
    logic [25:0] ra;
    logic [31:0] rd_v;

    // Reset and idle
    repeat (3) @(posedge sys_clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", dato, 32'd0);
    chk("rst_wrc", {16'd0, wrc}, 32'd0);
    chk("rst_rdc", {16'd0, rdc}, 32'd0);

    // Basic write then read
    transact(1'b1, 26'h10, 4'hF, 32'hDEADBEEF, "wr10");
    transact(1'b0, 26'h10, 4'hF, 32'h0, "rd10");
    chk("rd10_const", dato, 32'hDEADBEEF);
    chk("rd10_wrc1", {16'd0, wrc}, 32'd1);
    chk("rd10_rdc1", {16'd0, rdc}, 32'd1);

    // Partial byte-lane write
    transact(1'b1, 26'h20, 4'hF, 32'h11223344, "wr20");
    transact(1'b1, 26'h20, 4'b0101, 32'hAABBCCDD, "wr20p");
    transact(1'b0, 26'h20, 4'h0, 32'h0, "rd20");
    chk("rd20_const", dato, 32'h11BB33DD);

    // Out of range: read errors, write aliases to word 0 must not land
    transact(1'b1, 26'h0, 4'hF, 32'h01234567, "wr0");
    transact(1'b0, 26'h400, 4'hF, 32'h0, "rd400");
    transact(1'b1, 26'h400, 4'hF, 32'hFFFFFFFF, "wr400");
    transact(1'b0, 26'h0, 4'hF, 32'h0, "rd0");
    chk("rd0_const", dato, 32'h01234567);

    // Back-to-back: request held for 6 cycles
    we = 1'b1; addr = 26'h0; sel = 4'hF; dati = 32'hCAFE0001; cyc = 1'b1; stb = 1'b1;
    pat = '0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1;
      pat = {pat[4:0], ack};
      if (ack) nack++;
    end
    cyc = 1'b0; stb = 1'b0;
    mdl[0] = 32'hCAFE0001;
    mwr = mwr + 16'd3;
    chk("b2b_nack", nack, 32'd3);
    chk("b2b_pat", {26'd0, pat}, 32'h2A);
    chk("b2b_wrc", {16'd0, wrc}, {16'd0, mwr});
    @(posedge sys_clk); #1;
    transact(1'b0, 26'h0, 4'hF, 32'h0, "b2b_rd");

    // Random: initialise every word, then random transfers
    for (int i = 0; i < 256; i++)
      transact(1'b1, 26'(i * 4), 4'hF, $urandom, "init");
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        ra = 26'($urandom_range(0, 255) * 4);
        rd_v = $urandom;
        we = 1'b1; addr = ra; sel = 4'hF; dati = rd_v; cyc = 1'b1; stb = 1'b1;
        @(posedge sys_clk); #1;
        chk("mrst_pre_ack", {31'd0, ack}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_ack", {31'd0, ack}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_wrc", {16'd0, wrc}, 32'd0);
        chk("mrst_rdc", {16'd0, rdc}, 32'd0);
        chk("mrst_dat", dato, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        mdl[int'(ra) / 4] = rd_v;
        mwr = 16'd0; mrd = 16'd0; m_dat = 32'd0;
        @(posedge sys_clk); #1;
        chk("mrst_post_ack", {31'd0, ack}, 32'd0);
        transact(1'b0, ra, 4'hF, 32'h0, "mrst_rd");
        chk("mrst_rd_val", dato, rd_v);
      end
      transact(1'($urandom_range(0, 1)), 26'($urandom_range(0, 255) * 4),
               4'($urandom_range(0, 15)), $urandom, "rnd");
    end
    chk("final_wrc", {16'd0, wrc}, {16'd0, mwr});
    chk("final_rdc", {16'd0, rdc}, {16'd0, mrd});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/duv_top.md
Name: duv_top

Overview:
- Wishbone-classic slave memory block used as the device under test in the write/read verification environment.
- Accepts single 32-bit read/write transfers with byte selects and stores data in an internal word-addressed array.
- Answers every transfer with a one-cycle ack, or with a one-cycle err for out-of-range addresses.
- Keeps transfer counters for scoreboard cross-checks; sits directly behind the bus-functional driver.

Parameters:
- DW, 32, data width in bits (byte lanes = DW/8).
- AW, 8, word-address width; array depth = 2**AW words.
- BAW, 26, byte-address width of the bus address port.

Ports:
- sys_clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe; a request is cyc & stb.
- wb_we_i  in  1  1=write, 0=read.
- wb_addr_i  in  BAW  byte address; bits [1:0] are ignored.
- wb_sel_i  in  DW/8  byte-lane enables for writes.
- wb_dat_i  in  DW  write data.
- wb_dat_o  out  DW  read data, valid while wb_ack_o=1.
- wb_ack_o  out  1  one-cycle transfer-done pulse.
- wb_err_o  out  1  one-cycle error pulse for out-of-range addresses.
- wr_count  out  16  number of completed (acked) writes, wraps at 16'hFFFF to 0.
- rd_count  out  16  number of completed (acked) reads, wraps at 16'hFFFF to 0.

Behaviour:
- Reset (async, rst=1):
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wr_count=0, rd_count=0, FSM goes to IDLE.
  - The memory array is not reset; its contents are undefined until written.
- FSM has two states, IDLE and RESP.
- IDLE:
  - With cyc & stb, the request is accepted at that rising edge and the FSM moves to RESP.
  - With no request, the FSM stays in IDLE.
- Address decode:
  - Word index = wb_addr_i[AW+1:2].
  - The address is in range if and only if wb_addr_i[BAW-1:AW+2] == 0.
- Accepted write, in range:
  - At the acceptance edge, each byte lane i with wb_sel_i[i]=1 gets wb_dat_i[8i+7:8i]; other lanes keep their contents.
  - wb_sel_i=0 writes nothing but still acks and still counts.
- Accepted read, in range: the array word is registered into wb_dat_o at the acceptance edge.
- Out of range:
  - No array change.
  - wb_dat_o=0.
  - wb_err_o is pulsed instead of wb_ack_o.
  - Counters are unchanged.
- RESP:
  - wb_ack_o (or wb_err_o) is 1 for exactly this one cycle, then the FSM returns to IDLE unconditionally.
  - The counter increments on entry to RESP, so its value is visible together with the ack.
- Latency and throughput:
  - Ack is seen in the cycle after the request is sampled.
  - At most one transfer every 2 cycles, because a request held through RESP is not re-accepted.
  - The master must drop stb or change the request after the ack.
- wb_dat_o holds its last value outside RESP. Writes do not change wb_dat_o.
- ack and err are never both 1.
- Read-after-write to the same address in consecutive transfers returns the new data (there is no bypass hazard, since the write commits before the read is accepted).
- cyc/stb dropped while in RESP: the ack/err pulse still occurs; a committed write remains.
- rst asserted mid-transfer: the pending ack/err is cancelled and the FSM returns to IDLE; an already-committed write stays in the array.

Decomposition:
- Shared package duv_pkg holds:
  - the DW, AW and BAW defaults;
  - typedef state_t {IDLE, RESP};
  - typedefs wb_addr_t, wb_data_t, wb_sel_t.
- One sub-module, duv_bytemem: a single-port array with per-byte write enable and registered read, AW/DW parameters, no reset.
- duv_top holds the FSM, address decode, response flags and counters.

Test Plan:
- Reset, then idle for 5 cycles -> ack=err=0, wb_dat_o=0, wr_count=rd_count=0.
- Write 32'hDEADBEEF to byte address 0x10 with sel=4'hF, then read 0x10 -> ack one cycle after each request; read data 32'hDEADBEEF; wr_count=1, rd_count=1.
- Write 32'h11223344 to 0x20 with sel=4'hF, then write 32'hAABBCCDD with sel=4'b0101, then read 0x20 -> 32'h11BB33DD.
- Read byte address 0x400 (AW=8, out of range) -> err one cycle, ack=0, wb_dat_o=0, rd_count unchanged; a write to 0x400 leaves the array intact.
- Back-to-back: hold cyc/stb for 6 cycles with a write to 0x0 -> exactly 3 acks on alternate cycles, wr_count=3.
- Random: 1000 transfers with random addresses 0..0x3FC, we, sel and data, checked against a reference model -> every read matches; counters equal the acked write/read totals; rst pulsed mid-run cancels the pending ack.
